// File: rtl/i2c_init_sequencer_if.sv
// Shared transaction type and the request/response port between the
// init sequencer (master) and the i2c_controller (slave).
package i2c_init_sequencer_pkg;
  typedef enum logic {
    WRITE_8BIT_REGISTER = 1'b0,
    READ_8BIT           = 1'b1
  } i2c_transaction_t;
endpackage

interface i2c_init_sequencer_if;
  import i2c_init_sequencer_pkg::*;

  i2c_transaction_t i2c_mode;
  logic             i2c_i_valid;
  logic             i2c_i_ready;
  logic [6:0]       i2c_i_addr;
  logic [7:0]       i2c_i_data;
  logic             i2c_o_ready;
  logic             i2c_o_valid;
  logic [7:0]       i2c_o_data;

  modport master (
    output i2c_mode, i2c_i_valid, i2c_i_addr, i2c_i_data, i2c_o_ready,
    input  i2c_i_ready, i2c_o_valid, i2c_o_data
  );

  modport slave (
    input  i2c_mode, i2c_i_valid, i2c_i_addr, i2c_i_data, i2c_o_ready,
    output i2c_i_ready, i2c_o_valid, i2c_o_data
  );
endinterface

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a synchronous command ROM (write / delay /
// poll / end) and drives the i2c_controller request port through a device
// bring-up sequence. Reports done, or error with the failing table index.
module i2c_init_sequencer
  import i2c_init_sequencer_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h10,
  parameter int unsigned ROM_DEPTH      = 32,
  parameter int unsigned DELAY_UNIT     = 12000,
  parameter int unsigned MAX_POLLS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  localparam int unsigned AW            = $clog2(ROM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_index,
  output logic [AW-1:0] rom_addr,
  input  logic [17:0]   rom_data,
  i2c_init_sequencer_if.master i2c
);

  localparam int unsigned UW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam int unsigned PW = $clog2(MAX_POLLS + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [UW-1:0] UNIT_LAST = UW'(DELAY_UNIT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(ROM_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_START,
    S_WAIT_DONE, S_DELAY, S_CHECK, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_DELAY = 2'b01,
    OP_POLL  = 2'b10,
    OP_END   = 2'b11
  } op_t;

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [AW-1:0]    r_err_index;
  i2c_transaction_t r_mode;
  logic             r_issue;
  logic             r_o_ready;
  logic [7:0]       r_i_data;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [7:0]       r_rd;
  logic             r_got;
  logic [PW-1:0]    r_polls;
  logic [UW-1:0]    r_unit_cnt;
  logic [15:0]      r_units;
  logic [WW-1:0]    r_wdog;

  op_t              w_op;
  logic [7:0]       w_a;
  logic [7:0]       w_b;
  logic [15:0]      w_count;
  logic             w_last_idx;
  logic             w_wdog_hit;
  logic             w_match;
  logic             w_xfer_done;

  assign w_op        = op_t'(rom_data[17:16]);
  assign w_a         = rom_data[15:8];
  assign w_b         = rom_data[7:0];
  assign w_count     = rom_data[15:0];
  assign w_last_idx  = (r_idx == IDX_LAST);
  assign w_match     = ((r_rd & r_b) == (r_a & r_b));
  assign w_wdog_hit  = ((r_state == S_ISSUE) || (r_state == S_WAIT_START) ||
                        (r_state == S_WAIT_DONE)) && (r_wdog == WDOG_LAST);
  // A read completes only once both the idle indication and the byte have
  // been seen; they may arrive in either order.
  assign w_xfer_done = i2c.i2c_i_ready && ((r_mode == WRITE_8BIT_REGISTER) || r_got);

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_index = r_err_index;
  assign rom_addr  = r_idx;

  assign i2c.i2c_mode    = r_mode;
  assign i2c.i2c_i_addr  = DEV_ADDR;
  assign i2c.i2c_i_data  = r_i_data;
  assign i2c.i2c_o_ready = r_o_ready;
  // Request is gated by ready so the strobe never appears while the
  // controller is still busy.
  assign i2c.i2c_i_valid = r_issue & i2c.i2c_i_ready;

  // Sequencer FSM: fetch/decode table entries, run the I2C handshake, delays and polls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_mode      <= WRITE_8BIT_REGISTER;
      r_issue     <= 1'b0;
      r_o_ready   <= 1'b0;
      r_i_data    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_got       <= 1'b0;
      r_polls     <= '0;
      r_unit_cnt  <= '0;
      r_units     <= '0;
      r_wdog      <= '0;
    end else if (w_wdog_hit) begin
      r_err_index <= r_idx;
      r_error     <= 1'b1;
      r_busy      <= 1'b0;
      r_issue     <= 1'b0;
      r_o_ready   <= 1'b0;
      r_state     <= S_ERROR;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_polls <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: r_state <= S_DECODE;

        S_DECODE: begin
          case (w_op)
            OP_WRITE: begin
              r_i_data <= w_a;
              r_mode   <= WRITE_8BIT_REGISTER;
              r_issue  <= 1'b1;
              r_wdog   <= '0;
              r_state  <= S_ISSUE;
            end
            OP_POLL: begin
              r_a     <= w_a;
              r_b     <= w_b;
              r_mode  <= READ_8BIT;
              r_issue <= 1'b1;
              r_wdog  <= '0;
              r_state <= S_ISSUE;
            end
            OP_DELAY: begin
              if (w_count == 16'd0) begin
                if (w_last_idx) begin
                  r_done <= 1'b1; r_busy <= 1'b0; r_state <= S_DONE;
                end else begin
                  r_idx <= r_idx + 1'b1; r_state <= S_FETCH;
                end
              end else begin
                r_units    <= w_count;
                r_unit_cnt <= '0;
                r_state    <= S_DELAY;
              end
            end
            OP_END: begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end
          endcase
        end

        S_ISSUE: begin
          r_wdog <= r_wdog + 1'b1;
          if (i2c.i2c_i_ready) begin
            r_issue <= 1'b0;
            r_state <= S_WAIT_START;
          end
        end

        S_WAIT_START: begin
          r_wdog <= r_wdog + 1'b1;
          if (!i2c.i2c_i_ready) begin
            r_o_ready <= (r_mode == READ_8BIT);
            r_got     <= 1'b0;
            r_state   <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          r_wdog <= r_wdog + 1'b1;
          if (i2c.i2c_o_valid && r_o_ready) begin
            r_rd      <= i2c.i2c_o_data;
            r_got     <= 1'b1;
            r_o_ready <= 1'b0;
          end
          if (w_xfer_done) begin
            if (r_mode == READ_8BIT) begin
              r_state <= S_CHECK;
            end else if (w_last_idx) begin
              r_done <= 1'b1; r_busy <= 1'b0; r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 1'b1; r_state <= S_FETCH;
            end
          end
        end

        // Two-level count: unit counter wraps every DELAY_UNIT cycles and
        // decrements the unit count, avoiding a wide multiply.
        S_DELAY: begin
          if (r_unit_cnt == UNIT_LAST) begin
            r_unit_cnt <= '0;
            if (r_units == 16'd1) begin
              if (w_last_idx) begin
                r_done <= 1'b1; r_busy <= 1'b0; r_state <= S_DONE;
              end else begin
                r_idx <= r_idx + 1'b1; r_state <= S_FETCH;
              end
            end else begin
              r_units <= r_units - 16'd1;
            end
          end else begin
            r_unit_cnt <= r_unit_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          if (w_match) begin
            r_polls <= '0;
            if (w_last_idx) begin
              r_done <= 1'b1; r_busy <= 1'b0; r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + 1'b1; r_state <= S_FETCH;
            end
          end else if (r_polls == POLL_LAST) begin
            r_err_index <= r_idx;
            r_error     <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_ERROR;
          end else begin
            r_polls <= r_polls + 1'b1;
            r_issue <= 1'b1;
            r_wdog  <= '0;
            r_state <= S_ISSUE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
